// File: rtl/risc_core_p.sv
// risc_core_p: eight-phase accumulator core with a request/acknowledge memory port.
// Define RISC_CARRY_EN to build the ADD carry flag and its carry output port.
module risc_core_p #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [AWIDTH-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              halt,
    output logic [AWIDTH-1:0] pc,
    output logic [DWIDTH-1:0] acc,
    output logic [2:0]        phase
`ifdef RISC_CARRY_EN
    ,
    output logic              carry
`endif
);

    typedef enum logic [2:0] {
        PH_0 = 3'd0, PH_1 = 3'd1, PH_2 = 3'd2, PH_3 = 3'd3,
        PH_4 = 3'd4, PH_5 = 3'd5, PH_6 = 3'd6, PH_7 = 3'd7
    } phase_e;

    typedef enum logic [2:0] {
        OP_HLT = 3'b000, OP_SKZ = 3'b001, OP_ADD = 3'b010, OP_AND = 3'b011,
        OP_XOR = 3'b100, OP_LDA = 3'b101, OP_STO = 3'b110, OP_JMP = 3'b111
    } opcode_e;

    localparam logic [AWIDTH-1:0] PC_ONE = {{(AWIDTH-1){1'b0}}, 1'b1};

    phase_e            phase_q, phase_d;
    logic [AWIDTH-1:0] pc_q, pc_d;
    logic [DWIDTH-1:0] ir_q, ir_d;
    logic [DWIDTH-1:0] acc_q, acc_d;
    logic [DWIDTH-1:0] op_q, op_d;
    logic              halt_q, halt_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
    opcode_e           opcode_s;
    logic [AWIDTH-1:0] operand_s;
    logic [DWIDTH-1:0] alu_s;
`ifdef RISC_CARRY_EN
    logic              carry_q, carry_d;
    logic [DWIDTH:0]   sum_s;
`endif

    function automatic opcode_e decode_op(input logic [DWIDTH-1:0] instr);
        return opcode_e'(instr[DWIDTH-1:DWIDTH-3]);
    endfunction

    function automatic logic is_alu(input opcode_e op);
        logic r;
        case (op)
            OP_ADD, OP_AND, OP_XOR, OP_LDA: r = 1'b1;
            default:                        r = 1'b0;
        endcase
        return r;
    endfunction

    // Bus request for the phase about to be entered, so the port pins come straight from flops.
    function automatic logic [AWIDTH+1:0] bus_next(input phase_e ph,
                                                   input logic [DWIDTH-1:0] instr,
                                                   input logic [AWIDTH-1:0] pcv);
        logic              rd;
        logic              wr;
        logic [AWIDTH-1:0] addr;
        opcode_e           op;
        op   = decode_op(instr);
        rd   = 1'b0;
        wr   = 1'b0;
        addr = pcv;
        case (ph)
            PH_1: rd = 1'b1;
            PH_5: begin
                if (is_alu(op)) begin
                    rd   = 1'b1;
                    addr = instr[AWIDTH-1:0];
                end else begin
                    rd = 1'b0;
                end
            end
            PH_7: begin
                if (op == OP_STO) begin
                    wr   = 1'b1;
                    addr = instr[AWIDTH-1:0];
                end else begin
                    wr = 1'b0;
                end
            end
            default: begin
                rd = 1'b0;
                wr = 1'b0;
            end
        endcase
        return {rd, wr, addr};
    endfunction

    assign opcode_s  = decode_op(ir_q);
    assign operand_s = ir_q[AWIDTH-1:0];

    // Accumulator result for the four ALU opcodes.
    always_comb begin
        alu_s = acc_q;
`ifdef RISC_CARRY_EN
        sum_s = {1'b0, acc_q} + {1'b0, op_q};
`endif
        case (opcode_s)
`ifdef RISC_CARRY_EN
            OP_ADD:  alu_s = sum_s[DWIDTH-1:0];
`else
            OP_ADD:  alu_s = acc_q + op_q;
`endif
            OP_AND:  alu_s = acc_q & op_q;
            OP_XOR:  alu_s = acc_q ^ op_q;
            OP_LDA:  alu_s = op_q;
            default: alu_s = acc_q;
        endcase
    end

    // Phase sequencing and register updates; stalls hold the phase until mem_ack.
    always_comb begin
        phase_d = phase_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        acc_d   = acc_q;
        op_d    = op_q;
        halt_d  = halt_q;
`ifdef RISC_CARRY_EN
        carry_d = carry_q;
`endif
        if (halt_q) begin
            if (start) begin
                halt_d  = 1'b0;
                phase_d = PH_0;
            end else begin
                phase_d = PH_4;
            end
        end else begin
            case (phase_q)
                PH_0: phase_d = PH_1;
                PH_1: begin
                    if (mem_ack) begin
                        ir_d    = mem_rdata;
                        phase_d = PH_2;
                    end else begin
                        phase_d = PH_1;
                    end
                end
                PH_2: begin
                    pc_d    = pc_q + PC_ONE;
                    phase_d = PH_3;
                end
                PH_3: begin
                    // Halt is raised on entry to phase 4 so it is visible during that phase.
                    phase_d = PH_4;
                    if (opcode_s == OP_HLT) begin
                        halt_d = 1'b1;
                    end else begin
                        halt_d = 1'b0;
                    end
                end
                PH_4: phase_d = PH_5;
                PH_5: begin
                    if (!is_alu(opcode_s)) begin
                        phase_d = PH_6;
                    end else if (mem_ack) begin
                        op_d    = mem_rdata;
                        phase_d = PH_6;
                    end else begin
                        phase_d = PH_5;
                    end
                end
                PH_6: begin
                    phase_d = PH_7;
                    case (opcode_s)
                        OP_SKZ: begin
                            if (acc_q == {DWIDTH{1'b0}}) begin
                                pc_d = pc_q + PC_ONE;
                            end else begin
                                pc_d = pc_q;
                            end
                        end
                        OP_JMP:  pc_d = operand_s;
                        default: pc_d = pc_q;
                    endcase
                end
                PH_7: begin
                    if (is_alu(opcode_s)) begin
                        acc_d   = alu_s;
                        phase_d = PH_0;
`ifdef RISC_CARRY_EN
                        if (opcode_s == OP_ADD) begin
                            carry_d = sum_s[DWIDTH];
                        end else begin
                            carry_d = carry_q;
                        end
`endif
                    end else if (opcode_s != OP_STO) begin
                        phase_d = PH_0;
                    end else if (mem_ack) begin
                        phase_d = PH_0;
                    end else begin
                        phase_d = PH_7;
                    end
                end
                default: phase_d = PH_0;
            endcase
        end
    end

    // Next-cycle memory request derived from the next architectural state.
    always_comb begin
        {mem_rd_d, mem_wr_d, mem_addr_d} = bus_next(phase_d, ir_d, pc_d);
    end

    // Phase state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= PH_0;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Architectural registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q   <= {AWIDTH{1'b0}};
            ir_q   <= {DWIDTH{1'b0}};
            acc_q  <= {DWIDTH{1'b0}};
            op_q   <= {DWIDTH{1'b0}};
            halt_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            ir_q   <= ir_d;
            acc_q  <= acc_d;
            op_q   <= op_d;
            halt_q <= halt_d;
        end
    end

`ifdef RISC_CARRY_EN
    // Carry flag, written only by ADD.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

    assign carry = carry_q;
`endif

    // Registered memory port; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= {AWIDTH{1'b0}};
        end else begin
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = acc_q;
    assign halt      = halt_q;
    assign pc        = pc_q;
    assign acc       = acc_q;
    assign phase     = phase_q;

endmodule

// File: tb/tb_risc_core_p.sv
// Directed bench for risc_core_p: small programs against a behavioural memory with
// configurable acknowledge latency; expected values are hand-derived cycle counts.
module tb_risc_core_p;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] mem_addr;
    logic       mem_rd;
    logic       mem_wr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ack;
    logic       halt;
    logic [4:0] pc;
    logic [7:0] acc;
    logic [2:0] phase;
`ifdef RISC_CARRY_EN
    logic       carry;
`endif

    logic [7:0] mem [0:31];
    int         lat;
    int         wait_cnt;
    int         n_total = 0;
    int         n_pass  = 0;
    int         n_fail  = 0;
    logic       any_x;

    risc_core_p #(.AWIDTH(5), .DWIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .halt      (halt),
        .pc        (pc),
        .acc       (acc),
        .phase     (phase)
`ifdef RISC_CARRY_EN
        ,
        .carry     (carry)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: the memory answers at the negedge from the registered request,
    // writes land at the posedge, and the caller resumes 1 time unit after it.
    task automatic cycle();
        logic       req;
        logic       do_wr;
        logic [4:0] wa;
        logic [7:0] wd;
        @(negedge clk);
        req = mem_rd | mem_wr;
        if (lat == 0) mem_ack = 1'b1;
        else          mem_ack = req && (wait_cnt >= lat);
        mem_rdata = mem[mem_addr];
        do_wr = mem_wr & mem_ack;
        wa    = mem_addr;
        wd    = mem_wdata;
        @(posedge clk);
        if (do_wr) mem[wa] = wd;
        if (req && !mem_ack) wait_cnt++;
        else                 wait_cnt = 0;
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_phase"}, phase, 3'd0);
        check({tag, "_pc"}, pc, 5'd0);
        check({tag, "_acc"}, acc, 8'd0);
        check({tag, "_halt"}, halt, 1'b0);
        check({tag, "_rd"}, mem_rd, 1'b0);
        check({tag, "_wr"}, mem_wr, 1'b0);
        check({tag, "_addr"}, mem_addr, 5'd0);
`ifdef RISC_CARRY_EN
        check({tag, "_carry"}, carry, 1'b0);
`endif
    endtask

    // Reset is released 2 units after a posedge, so the next cycle() is edge 1.
    task automatic apply_reset(input string tag);
        @(negedge clk);
        rst      = 1'b0;
        start    = 1'b0;
        mem_ack  = 1'b0;
        wait_cnt = 0;
        #1;
        check_reset_state(tag);
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    task automatic load_main();
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        mem[0]     = 8'hB0;  // LDA 0x10
        mem[1]     = 8'h51;  // ADD 0x11
        mem[2]     = 8'hD2;  // STO 0x12
        mem[3]     = 8'h00;  // HLT
        mem[4]     = 8'hB3;  // LDA 0x13
        mem[5]     = 8'h20;  // SKZ
        mem[6]     = 8'h00;  // HLT
        mem[7]     = 8'h00;  // HLT
        mem[5'h10] = 8'h05;
        mem[5'h11] = 8'h07;
        mem[5'h13] = 8'h00;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        lat       = 0;
        wait_cnt  = 0;
        any_x     = 1'b0;

        // Zero-wait main program: fetch from 0 at edge 1, halt at edge 28.
        load_main();
        lat = 0;
        apply_reset("rst0");
        cycle();
        check("fetch0_phase", phase, 3'd1);
        check("fetch0_rd", mem_rd, 1'b1);
        check("fetch0_wr", mem_wr, 1'b0);
        check("fetch0_addr", mem_addr, 5'd0);
        run(26);
        check("c27_phase", phase, 3'd3);
        check("c27_halt", halt, 1'b0);
        cycle();
        check("c28_halt", halt, 1'b1);
        check("c28_phase", phase, 3'd4);
        check("c28_pc", pc, 5'd4);
        check("c28_acc", acc, 8'h0C);
        check("c28_mem12", mem[5'h12], 8'h0C);

        // Halted core holds; a start pulse resumes at pc 4, then SKZ with acc=0 skips.
        run(3);
        check("hold_phase", phase, 3'd4);
        check("hold_halt", halt, 1'b1);
        check("hold_pc", pc, 5'd4);
        start = 1'b1;
        cycle();
        start = 1'b0;
        check("resume_halt", halt, 1'b0);
        check("resume_phase", phase, 3'd0);
        check("resume_pc", pc, 5'd4);
        cycle();
        check("resume_fetch_rd", mem_rd, 1'b1);
        check("resume_fetch_addr", mem_addr, 5'd4);
        run(16);
        check("skz0_acc", acc, 8'h00);
        check("skz0_fetch_rd", mem_rd, 1'b1);
        check("skz0_fetch_addr", mem_addr, 5'd7);

        // Three-cycle acknowledge latency with start pulses while running.
        load_main();
        lat = 3;
        apply_reset("rst1");
        for (int k = 1; k <= 49; k++) begin
            start = (k >= 6 && k <= 10);
            cycle();
            if (k <= 4) begin
                check("stall_fetch_rd", mem_rd, 1'b1);
                check("stall_fetch_addr", mem_addr, 5'd0);
                check("stall_fetch_phase", phase, 3'd1);
            end
            if (k == 5) begin
                check("fetch_done_rd", mem_rd, 1'b0);
                check("fetch_done_phase", phase, 3'd2);
            end
            if (k >= 38 && k <= 41) begin
                check("stall_sto_wr", mem_wr, 1'b1);
                check("stall_sto_rd", mem_rd, 1'b0);
                check("stall_sto_addr", mem_addr, 5'h12);
                check("stall_sto_wdata", mem_wdata, 8'h0C);
            end
            if (k == 42) check("sto_done_wr", mem_wr, 1'b0);
            if (k == 48) check("lat3_c48_halt", halt, 1'b0);
        end
        check("lat3_halt", halt, 1'b1);
        check("lat3_phase", phase, 3'd4);
        check("lat3_pc", pc, 5'd4);
        check("lat3_acc", acc, 8'h0C);
        check("lat3_mem12", mem[5'h12], 8'h0C);

        // JMP to 4, LDA 1, SKZ at pc 5 does not skip: next fetch from 6.
        load_main();
        mem[0]     = 8'hE4;
        mem[5'h13] = 8'h01;
        lat = 0;
        apply_reset("rst2");
        run(9);
        check("jmp_fetch_addr", mem_addr, 5'd4);
        check("jmp_fetch_rd", mem_rd, 1'b1);
        run(16);
        check("skz1_fetch_addr", mem_addr, 5'd6);
        check("skz1_fetch_rd", mem_rd, 1'b1);
        run(3);
        check("skz1_halt", halt, 1'b1);
        check("skz1_pc", pc, 5'd7);
        check("skz1_acc", acc, 8'h01);

        // pc wrap: JMP 0x1F at 0x1F increments to 0 then reloads 0x1F.
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        mem[0]     = 8'hFF;
        mem[5'h1F] = 8'hFF;
        apply_reset("rst3");
        any_x = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            cycle();
            any_x = any_x | $isunknown({mem_addr, mem_rd, mem_wr, mem_wdata, halt, pc, acc, phase});
            if (k == 9) check("wrap_fetch_addr", mem_addr, 5'h1F);
            if (k == 10) check("wrap_pc_before", pc, 5'h1F);
            if (k == 11) check("wrap_pc_zero", pc, 5'h00);
            if (k == 15) check("wrap_pc_reload", pc, 5'h1F);
            if (k == 17) check("wrap_refetch_addr", mem_addr, 5'h1F);
        end
        check("wrap_no_x", any_x, 1'b0);

        // ALU program: LDA F0, ADD 20 (wraps), AND 20, XOR 5A, HLT.
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        mem[0]     = 8'hB0;
        mem[1]     = 8'h51;
        mem[2]     = 8'h71;
        mem[3]     = 8'h92;
        mem[4]     = 8'h00;
        mem[5'h10] = 8'hF0;
        mem[5'h11] = 8'h20;
        mem[5'h12] = 8'h5A;
        apply_reset("rst4");
        run(8);
        check("alu_lda_acc", acc, 8'hF0);
`ifdef RISC_CARRY_EN
        check("alu_lda_carry", carry, 1'b0);
`endif
        run(8);
        check("alu_add_acc", acc, 8'h10);
`ifdef RISC_CARRY_EN
        check("alu_add_carry", carry, 1'b1);
`endif
        run(8);
        check("alu_and_acc", acc, 8'h00);
`ifdef RISC_CARRY_EN
        check("alu_and_carry", carry, 1'b1);
`endif
        run(8);
        check("alu_xor_acc", acc, 8'h5A);
        run(4);
        check("alu_halt", halt, 1'b1);
        check("alu_pc", pc, 5'd5);

        // Reset in the middle of a stalled phase-5 read, then a clean rerun.
        load_main();
        lat = 3;
        apply_reset("rst5");
        run(8);
        check("midstall_phase", phase, 3'd5);
        check("midstall_rd", mem_rd, 1'b1);
        check("midstall_addr", mem_addr, 5'h10);
        #1;
        rst = 1'b0;
        #1;
        check_reset_state("midstall_rst");
        lat      = 0;
        wait_cnt = 0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        cycle();
        check("rerun_fetch_phase", phase, 3'd1);
        check("rerun_fetch_addr", mem_addr, 5'd0);
        run(27);
        check("rerun_halt", halt, 1'b1);
        check("rerun_pc", pc, 5'd4);
        check("rerun_acc", acc, 8'h0C);
        check("rerun_mem12", mem[5'h12], 8'h0C);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
